// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential multiplier issue stage:
// FSM encoding, default operand width and the core's worst-case latency.
package seq_mult_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_ABORT = 3'd4
   } state_t;

   // Longest time the shift-add core can take from go to done.
   function automatic int worst_case_cycles(input int width);
      return 3 * width + 4;
   endfunction

endpackage

// File: rtl/seq_mult_opfifo.sv
// Small synchronous operand FIFO with asynchronous active-low clear.
// Push while full and pop while empty are ignored.
module seq_mult_opfifo #(
   parameter int DW    = 16,
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   clr_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [DW-1:0]          din,
   output logic [DW-1:0]          dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   // Head is read combinationally so IDLE can latch it in the pop cycle.
   assign dout  = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/seq_mult_issue.sv
// Issue stage for the shift-add multiplier core: queues operand pairs, runs one
// multiplication at a time, returns products and aborts a hung core via watchdog.
module seq_mult_issue
   import seq_mult_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int DEPTH   = 2,
   parameter int TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               clr_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   output logic               mul_go,
   output logic [WIDTH-1:0]   mul_a,
   output logic [WIDTH-1:0]   mul_b,
   output logic               mul_clr,
   input  logic               mul_done,
   input  logic [2*WIDTH-1:0] mul_p,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_p,
   output logic               out_err,
   output logic               busy
);

   // A TIMEOUT at or below the core's worst case would abort healthy operations.
   localparam int WD_LIMIT = (TIMEOUT > worst_case_cycles(WIDTH)) ? TIMEOUT
                                                                  : worst_case_cycles(WIDTH) + 1;
   localparam int WD_W = $clog2(WD_LIMIT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);

   state_t              state;
   state_t              state_next;
   logic [WD_W-1:0]     watchdog;
   logic [2*WIDTH-1:0]  head;
   logic                fifo_full;
   logic                fifo_empty;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                pop;

   seq_mult_opfifo #(
      .DW    (2 * WIDTH),
      .DEPTH (DEPTH)
   ) u_opfifo (
      .clk   (clk),
      .clr_n (clr_n),
      .push  (in_valid && in_ready),
      .pop   (pop),
      .din   ({in_a, in_b}),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign pop      = (state == ST_IDLE) && !fifo_empty;
   assign in_ready = !fifo_full;
   assign mul_go   = (state == ST_ISSUE);
   assign mul_clr  = (state == ST_ABORT);
   assign busy     = (state != ST_IDLE) || (fifo_count != '0);

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE:  if (!fifo_empty) state_next = ST_ISSUE;
         ST_ISSUE: state_next = ST_WAIT;
         ST_WAIT: begin
            // A completion in the final watchdog cycle still counts as success.
            if (mul_done)                   state_next = ST_HOLD;
            else if (watchdog == WD_LAST)   state_next = ST_ABORT;
         end
         ST_ABORT: state_next = ST_HOLD;
         ST_HOLD:  if (out_ready) state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         watchdog  <= '0;
         mul_a     <= '0;
         mul_b     <= '0;
         out_valid <= 1'b0;
         out_p     <= '0;
         out_err   <= 1'b0;
      end else begin
         if (pop) {mul_a, mul_b} <= head;
         case (state)
            ST_ISSUE: watchdog <= '0;
            ST_WAIT: begin
               watchdog <= watchdog + WD_W'(1);
               if (mul_done) begin
                  out_p     <= mul_p;
                  out_err   <= 1'b0;
                  out_valid <= 1'b1;
               end
            end
            ST_ABORT: begin
               out_p     <= '0;
               out_err   <= 1'b1;
               out_valid <= 1'b1;
            end
            ST_HOLD: if (out_ready) out_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule
